// File: rtl/logger_ev_arbiter.sv
// Round-robin arbiter feeding one logger event port from N_SRC timestamper channels.
// Optional macro LOGGER_ARB_PRIO_EN gives source 0 strict priority over the rotation.
module logger_ev_arbiter #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 16,
  parameter int TS_W  = 64,
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_SRC-1:0]        in_valid,
  output logic [N_SRC-1:0]        in_ready,
  input  logic [N_SRC*ID_W-1:0]   in_id,
  input  logic [N_SRC*TS_W-1:0]   in_start,
  input  logic [N_SRC*TS_W-1:0]   in_end,
  input  logic [N_SRC*TS_W-1:0]   in_delta,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SRC_W-1:0]        out_src,
  output logic [ID_W-1:0]         out_id,
  output logic [TS_W-1:0]         out_start,
  output logic [TS_W-1:0]         out_end,
  output logic [TS_W-1:0]         out_delta,
  output logic                    busy
);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [TS_W-1:0] ts_start;
    logic [TS_W-1:0] ts_end;
    logic [TS_W-1:0] delta;
  } ev_t;

  ev_t [N_SRC-1:0]  src_ev;
  ev_t              out_ev;
  logic [SRC_W-1:0] rr_ptr, sel;
  logic             found, load_ok, grant;

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src_ev[i] = {in_id[i*ID_W +: ID_W], in_start[i*TS_W +: TS_W],
                        in_end[i*TS_W +: TS_W], in_delta[i*TS_W +: TS_W]};
  end

  // First valid source after rr_ptr, wrapping; rr_ptr itself is checked last.
  always_comb begin
    int idx;
    idx   = 0;
    sel   = '0;
    found = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % N_SRC;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        sel   = SRC_W'(idx);
      end
    end
`ifdef LOGGER_ARB_PRIO_EN
    if (in_valid[0]) begin
      found = 1'b1;
      sel   = '0;
    end
`endif
  end

  assign load_ok = ~out_valid | out_ready;
  // rst_n gating keeps in_ready quiet while reset is held.
  assign grant   = rst_n & en & load_ok & found;

  always_comb begin
    in_ready = '0;
    if (grant) in_ready[sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_src   <= '0;
      out_ev    <= '0;
      rr_ptr    <= SRC_W'(N_SRC - 1);
    end else if (grant) begin
      out_valid <= 1'b1;
      out_src   <= sel;
      out_ev    <= src_ev[sel];
`ifdef LOGGER_ARB_PRIO_EN
      // Priority grants to source 0 leave the rotation among 1..N_SRC-1 untouched.
      if (sel != '0) rr_ptr <= sel;
`else
      rr_ptr    <= sel;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_id    = out_ev.id;
  assign out_start = out_ev.ts_start;
  assign out_end   = out_ev.ts_end;
  assign out_delta = out_ev.delta;
  assign busy      = out_valid | (|in_valid);

endmodule

// File: tb/tb_logger_ev_arbiter.sv
// Table-driven bench for logger_ev_arbiter: per-cycle in_ready vectors plus a data scoreboard.
module tb_logger_ev_arbiter;
  localparam int N  = 4;
  localparam int IW = 16;
  localparam int TW = 64;
  localparam int SW = 2;

  logic            clk = 1'b0, rst_n = 1'b0, en = 1'b0, out_ready = 1'b0;
  logic [N-1:0]    in_valid = '0, in_ready;
  logic [N*IW-1:0] in_id;
  logic [N*TW-1:0] in_start, in_end, in_delta;
  logic            out_valid, busy;
  logic [SW-1:0]   out_src;
  logic [IW-1:0]   out_id;
  logic [TW-1:0]   out_start, out_end, out_delta;

  logic [IW-1:0] s_id [N];
  logic [TW-1:0] s_st [N], s_en [N], s_dl [N];

  typedef struct {
    logic [SW-1:0] src;
    logic [IW-1:0] id;
    logic [TW-1:0] st, en, dl;
  } exp_t;

  typedef struct {
    logic [N-1:0] vld;
    logic         en;
    logic         ordy;
    logic [N-1:0] rdy;
  } vec_t;

  exp_t sb [$];
  vec_t tbl [$];
  logic mvalid = 1'b0;
  int   checks = 0, errors = 0;

  logger_ev_arbiter #(.N_SRC(N), .ID_W(IW), .TS_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_id(in_id), .in_start(in_start), .in_end(in_end), .in_delta(in_delta),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_id(out_id), .out_start(out_start), .out_end(out_end), .out_delta(out_delta),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_id = '0; in_start = '0; in_end = '0; in_delta = '0;
    for (int i = 0; i < N; i++) begin
      in_id[i*IW +: IW]    = s_id[i];
      in_start[i*TW +: TW] = s_st[i];
      in_end[i*TW +: TW]   = s_en[i];
      in_delta[i*TW +: TW] = s_dl[i];
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic refresh(input int i);
    s_id[i] = IW'($urandom);
    s_st[i] = {$urandom, $urandom};
    s_en[i] = {$urandom, $urandom};
    s_dl[i] = {$urandom, $urandom};
  endtask

  task automatic add(input logic [N-1:0] v, input logic e, input logic o, input logic [N-1:0] r);
    tbl.push_back('{vld: v, en: e, ordy: o, rdy: r});
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic do_cycle(input logic [N-1:0] v, input logic e, input logic o,
                          input logic [N-1:0] r);
    exp_t cur;
    int   s;
    in_valid = v; en = e; out_ready = o;
    #1;
    chk("in_ready", in_ready, r);
    chk("out_valid", out_valid, mvalid);
    chk("busy", busy, mvalid | (|v));
    if (mvalid) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_underflow: got out_valid=1 expected no pending event");
      end else begin
        cur = sb[0];
        chk("out_src", out_src, cur.src);
        chk("out_id", out_id, cur.id);
        chk("out_start", out_start, cur.st);
        chk("out_end", out_end, cur.en);
        chk("out_delta", out_delta, cur.dl);
        if (o) void'(sb.pop_front());
      end
    end
    s = -1;
    for (int i = 0; i < N; i++) if (r[i]) s = i;
    if (s >= 0) sb.push_back('{src: SW'(s), id: s_id[s], st: s_st[s], en: s_en[s], dl: s_dl[s]});
    @(posedge clk);
    #1;
    if (s >= 0) begin
      refresh(s);
      mvalid = 1'b1;
    end else if (o) begin
      mvalid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) refresh(i);

`ifdef LOGGER_ARB_PRIO_EN
    repeat (4) add(4'hF, 1'b1, 1'b1, 4'b0001);
    add(4'b1110, 1'b1, 1'b1, 4'b0010);
    add(4'b1110, 1'b1, 1'b1, 4'b0100);
    add(4'b1110, 1'b1, 1'b1, 4'b1000);
    add(4'b0000, 1'b1, 1'b1, 4'b0000);
`else
    // fairness: 0,1,2,3,0,1
    add(4'hF, 1'b1, 1'b1, 4'b0001);
    add(4'hF, 1'b1, 1'b1, 4'b0010);
    add(4'hF, 1'b1, 1'b1, 4'b0100);
    add(4'hF, 1'b1, 1'b1, 4'b1000);
    add(4'hF, 1'b1, 1'b1, 4'b0001);
    add(4'hF, 1'b1, 1'b1, 4'b0010);
    // backpressure, then accept with same-cycle regrant
    repeat (10) add(4'hF, 1'b1, 1'b0, 4'b0000);
    add(4'hF, 1'b1, 1'b1, 4'b0100);
    add(4'h0, 1'b1, 1'b1, 4'b0000);
    // sparse: source 2 alone, then source 1 (wrap past 3,0)
    add(4'b0100, 1'b1, 1'b1, 4'b0100);
    add(4'b0010, 1'b1, 1'b1, 4'b0010);
    add(4'h0, 1'b1, 1'b1, 4'b0000);
    // enable: hold an event, drop en, drain, resume from rr_ptr+1
    add(4'hF, 1'b1, 1'b0, 4'b0100);
    add(4'hF, 1'b0, 1'b0, 4'b0000);
    add(4'hF, 1'b0, 1'b1, 4'b0000);
    add(4'hF, 1'b0, 1'b1, 4'b0000);
    add(4'hF, 1'b1, 1'b1, 4'b1000);
    add(4'hF, 1'b1, 1'b1, 4'b0001);
    // source 0 drops its request while the output is stalled
    add(4'h0, 1'b1, 1'b0, 4'b0000);
    add(4'b0011, 1'b1, 1'b1, 4'b0010);
    add(4'h0, 1'b1, 1'b1, 4'b0000);
    add(4'h0, 1'b1, 1'b1, 4'b0000);
`endif

    // reset with every source requesting
    rst_n = 1'b0; in_valid = '1; en = 1'b1; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_src", out_src, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_start", out_start, 0);
    chk("rst_out_delta", out_delta, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) do_cycle(tbl[k].vld, tbl[k].en, tbl[k].ordy, tbl[k].rdy);

    // reset while an event is held discards it
    do_cycle(4'b0100, 1'b1, 1'b0, 4'b0100);
    in_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_id", out_id, 0);
    sb.delete();
    mvalid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_cycle(4'hF, 1'b1, 1'b1, 4'b0001);
    do_cycle(4'h0, 1'b1, 1'b1, 4'b0000);

    chk("sb_drained", 64'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
